sync_fifo_cfg: RTL



---
 rtl/fifo_pkg.sv | 12 +
 rtl/sync_dp_ram.sv | 44 ++++
 rtl/sync_fifo_cfg.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings and the occupancy-count width helper.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Occupancy runs 0..depth inclusive, hence depth+1 states.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Single-clock dual-port RAM: one write port, one read port that is either
// registered (reset/flushable, holds when idle) or asynchronous, selected by REG_RD.
module sync_dp_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter bit REG_RD = 1'b1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_RD) begin : g_reg_rd
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata <= '0;
                end else if (clr) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_async_rd
            assign rdata = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO, any DEPTH, standard (1-cycle registered) or FWFT read; one write
// and one read per cycle; writes dropped when full, reads dropped when empty (sticky flags).
module sync_fifo_cfg
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_MODE_STD,
    localparam int CW      = fifo_count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             walmost_full,
    output logic             ralmost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (WIDTH < 1 || DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
            AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1 ||
            (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT)) begin : g_bad_param
            $error("sync_fifo_cfg: illegal parameter combination");
        end
    endgenerate

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wen;
    logic             ren;
    logic [WIDTH-1:0] ram_rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wen = winc & ~wfull  & ~clr;
    assign ren = rinc & ~rempty & ~clr;

    assign wfull         = (count == CW'(DEPTH));
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= CW'(AF_LEVEL));
    assign ralmost_empty = (count <= CW'(AE_LEVEL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wen) wptr <= next_ptr(wptr);
            if (ren) rptr <= next_ptr(rptr);
            case ({wen, ren})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    sync_dp_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .REG_RD (FWFT == FIFO_MODE_STD)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .we    (wen),
        .waddr (wptr),
        .wdata (wdata),
        .re    (ren),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // FWFT shows the head word directly; blank it when nothing valid is stored.
    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign rdata = rempty ? '0 : ram_rdata;
        end else begin : g_std
            assign rdata = ram_rdata;
        end
    endgenerate

endmodule
